// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode trap slice: CSR addresses,
// mtvec mode encodings, standard cause codes and the trap FSM states.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  localparam logic [4:0] CAUSE_ILLEGAL_INSTR = 5'd2;
  localparam logic [4:0] CAUSE_ECALL_M       = 5'd11;
  localparam logic [4:0] IRQ_M_TIMER         = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REDIRECT,
    ST_FLUSH
  } trap_state_e;

  // mstatus read image: MPP is hardwired to machine mode.
  function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
    logic [31:0] v;
    v       = '0;
    v[3]    = mie;
    v[7]    = mpie;
    v[12:11] = 2'b11;
    return v;
  endfunction

endpackage

// File: rtl/m_trap_vector_calc.sv
// Combinational trap target: vectored mode offsets interrupts by 4*cause,
// everything else lands on the aligned mtvec base.
module m_trap_vector_calc
  import csr_pkg::*;
(
  input  logic [31:0] mtvec,
  input  logic        trap_is_irq,
  input  logic [4:0]  trap_code,
  output logic [31:0] target
);

  logic [31:0] base;

  // Select base or base + (code << 2); the sum wraps at 32 bits.
  always_comb begin
    base   = {mtvec[31:2], 2'b00};
    target = base;
    if ((mtvec[1:0] == MTVEC_VECTORED) && trap_is_irq) begin
      target = base + {25'd0, trap_code, 2'b00};
    end
  end

endmodule

// File: rtl/m_trap_handler.sv
// Machine-mode trap entry/return unit: commits trap CSRs, issues a one-cycle
// PC redirect and then holds flush for FLUSH_CYCLES cycles in total.
// Optional: define M_TRAP_MSCRATCH_EN to add the mscratch CSR at 0x340.
module m_trap_handler
  import csr_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic        RESET_MIE    = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mtvec,
  input  logic        trap_req,
  input  logic        trap_is_irq,
  input  logic [4:0]  trap_code,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_val,
  input  logic        mret_req,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        busy,
  output logic        mstatus_mie
);

  localparam int unsigned CW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

  trap_state_e state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0]   mepc, mcause, mtval, target_q, vec_target;
  logic          mie, mpie;
  logic          idle, take_trap, take_mret, do_csr;
`ifdef M_TRAP_MSCRATCH_EN
  logic [31:0]   mscratch;
`endif

  m_trap_vector_calc u_vec (
    .mtvec       (mtvec),
    .trap_is_irq (trap_is_irq),
    .trap_code   (trap_code),
    .target      (vec_target)
  );

  // Request arbitration: only in IDLE, trap beats mret beats CSR write.
  always_comb begin
    idle      = (state == ST_IDLE);
    take_trap = idle && trap_req;
    take_mret = idle && !trap_req && mret_req;
    do_csr    = idle && !trap_req && !mret_req && csr_we;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next state and redirect/flush outputs.
  always_comb begin
    state_nx       = state;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    flush          = 1'b0;
    busy           = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (take_trap || take_mret) state_nx = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        flush          = 1'b1;
        busy           = 1'b1;
        state_nx       = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_IDLE;
      end
      ST_FLUSH: begin
        flush = 1'b1;
        busy  = 1'b1;
        if (cnt <= CW'(1)) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Flush counter: loaded on redirect, FLUSH exits once it would hit zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == ST_REDIRECT) begin
      cnt <= CW'(FLUSH_CYCLES - 1);
    end else if (state == ST_FLUSH) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Trap CSR updates and target latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
      target_q <= '0;
      mie      <= RESET_MIE;
      mpie     <= 1'b0;
`ifdef M_TRAP_MSCRATCH_EN
      mscratch <= '0;
`endif
    end else if (take_trap) begin
      mepc     <= {trap_pc[31:2], 2'b00};
      mcause   <= {trap_is_irq, 26'd0, trap_code};
      mtval    <= trap_val;
      mpie     <= mie;
      mie      <= 1'b0;
      target_q <= vec_target;
    end else if (take_mret) begin
      mie      <= mpie;
      mpie     <= 1'b1;
      target_q <= mepc;
    end else if (do_csr) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie  <= csr_wdata[3];
          mpie <= csr_wdata[7];
        end
        CSR_MEPC:   mepc   <= {csr_wdata[31:2], 2'b00};
        CSR_MCAUSE: mcause <= csr_wdata;
        CSR_MTVAL:  mtval  <= csr_wdata;
`ifdef M_TRAP_MSCRATCH_EN
        CSR_MSCRATCH: mscratch <= csr_wdata;
`endif
        default: ;
      endcase
    end
  end

  // Combinational CSR read port; unmapped addresses read zero.
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: csr_rdata = mstatus_pack(mie, mpie);
      CSR_MEPC:    csr_rdata = mepc;
      CSR_MCAUSE:  csr_rdata = mcause;
      CSR_MTVAL:   csr_rdata = mtval;
`ifdef M_TRAP_MSCRATCH_EN
      CSR_MSCRATCH: csr_rdata = mscratch;
`endif
      default: csr_rdata = '0;
    endcase
  end

  assign mstatus_mie = mie;

endmodule

// File: tb/tb_m_trap_handler.sv
// Self-checking bench for m_trap_handler: vector table plus redirect scoreboard.
module tb_m_trap_handler;
  import csr_pkg::*;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mtvec;
  logic        trap_req, trap_is_irq, mret_req, csr_we;
  logic [4:0]  trap_code;
  logic [31:0] trap_pc, trap_val, csr_wdata, csr_rdata, redirect_pc;
  logic [11:0] csr_addr;
  logic        redirect_valid, flush, busy, mstatus_mie;

  int total = 0;
  int bad   = 0;
  logic [31:0] sbq[$];

  m_trap_handler #(.FLUSH_CYCLES(FC), .RESET_MIE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .mtvec(mtvec),
    .trap_req(trap_req), .trap_is_irq(trap_is_irq), .trap_code(trap_code),
    .trap_pc(trap_pc), .trap_val(trap_val), .mret_req(mret_req),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .busy(busy),
    .mstatus_mie(mstatus_mie)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Scoreboard: every redirect pulse must match the oldest expected target.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && redirect_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL redirect_extra: got 0x%08h expected no redirect", redirect_pc);
      end else begin
        chk("redirect_pc", redirect_pc, sbq.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (flush === 1'b1 && n < 16) begin
      n++;
      @(negedge clk);
    end
    chk(nm, n, FC);
    chk("busy_after", busy, 0);
  endtask

  task automatic run_req(input bit is_mret, input logic irq, input logic [4:0] code,
                         input logic [31:0] pc, input logic [31:0] val, input logic [31:0] exp);
    @(negedge clk);
    trap_req = !is_mret; mret_req = is_mret;
    trap_is_irq = irq; trap_code = code; trap_pc = pc; trap_val = val;
    sbq.push_back(exp);
    @(negedge clk);
    trap_req = 0; mret_req = 0;
    chk("redirect_latency", redirect_valid, 1);
    wait_idle("flush_len");
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_we = 1; csr_addr = a; csr_wdata = d;
    @(negedge clk);
    csr_we = 0;
  endtask

  task automatic csr_read(input string nm, input logic [11:0] a, input logic [31:0] exp);
    @(negedge clk);
    csr_addr = a;
    #1;
    chk(nm, csr_rdata, exp);
  endtask

  typedef struct {
    int          op;   // 0 set mtvec, 1 trap, 2 mret, 3 csr write, 4 csr read
    logic        irq;
    logic [4:0]  code;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t vt[$];
  logic [31:0] ms_exp;

  initial begin
`ifdef M_TRAP_MSCRATCH_EN
    ms_exp = 32'hCAFE_F00D;
`else
    ms_exp = 32'h0;
`endif
    vt = '{
      '{0, 0, 5'd0, 32'h0000_0004, 0, 0, "mtvec"},
      '{3, 0, 5'd0, 32'h300, 32'h8, 0, "wr_mstatus"},
      '{4, 0, 5'd0, 32'h300, 0, 32'h1808, "mstatus_mie1"},
      '{1, 0, CAUSE_ILLEGAL_INSTR, 32'h100, 32'hDEAD_BEEF, 32'h4, "t1"},
      '{4, 0, 5'd0, 32'h341, 0, 32'h100, "t1_mepc"},
      '{4, 0, 5'd0, 32'h342, 0, 32'h2, "t1_mcause"},
      '{4, 0, 5'd0, 32'h343, 0, 32'hDEAD_BEEF, "t1_mtval"},
      '{4, 0, 5'd0, 32'h300, 0, 32'h1880, "t1_mstatus"},
      '{2, 0, 5'd0, 0, 0, 32'h100, "mret"},
      '{4, 0, 5'd0, 32'h300, 0, 32'h1888, "mret_mstatus"},
      '{0, 0, 5'd0, 32'h0000_1001, 0, 0, "mtvec"},
      '{1, 1, IRQ_M_TIMER, 32'h207, 0, 32'h101C, "t2_irq"},
      '{4, 0, 5'd0, 32'h342, 0, 32'h8000_0007, "t2_mcause"},
      '{4, 0, 5'd0, 32'h341, 0, 32'h204, "t2_mepc_align"},
      '{1, 0, CAUSE_ECALL_M, 32'h208, 32'h5, 32'h1000, "t3_exc"},
      '{4, 0, 5'd0, 32'h342, 0, 32'hB, "t3_mcause"},
      '{0, 0, 5'd0, 32'hFFFF_FFFD, 0, 0, "mtvec"},
      '{1, 1, 5'd3, 32'h10, 0, 32'h0000_0008, "t4_wrap"},
      '{0, 0, 5'd0, 32'h0000_1003, 0, 0, "mtvec"},
      '{1, 1, 5'd7, 32'h10, 0, 32'h0000_1000, "t5_mode3"},
      '{3, 0, 5'd0, 32'h341, 32'h0000_0203, 0, "wr_mepc"},
      '{4, 0, 5'd0, 32'h341, 0, 32'h0000_0200, "mepc_mask"},
      '{3, 0, 5'd0, 32'h300, 32'hFFFF_FFFF, 0, "wr_mstatus"},
      '{4, 0, 5'd0, 32'h300, 0, 32'h0000_1888, "mstatus_mask"},
      '{3, 0, 5'd0, 32'h342, 32'h1234_5678, 0, "wr_mcause"},
      '{4, 0, 5'd0, 32'h342, 0, 32'h1234_5678, "mcause_rw"},
      '{3, 0, 5'd0, 32'h343, 32'hA5A5_0F0F, 0, "wr_mtval"},
      '{4, 0, 5'd0, 32'h343, 0, 32'hA5A5_0F0F, "mtval_rw"},
      '{3, 0, 5'd0, 32'h123, 32'hFFFF_FFFF, 0, "wr_unmapped"},
      '{4, 0, 5'd0, 32'h123, 0, 32'h0, "unmapped_rd"},
      '{3, 0, 5'd0, 32'h340, 32'hCAFE_F00D, 0, "wr_mscratch"},
      '{4, 0, 5'd0, 32'h340, 0, ms_exp, "mscratch"}
    };

    rst_n = 0; mtvec = 0; trap_req = 0; trap_is_irq = 0; trap_code = 0;
    trap_pc = 0; trap_val = 0; mret_req = 0; csr_we = 0; csr_addr = 0; csr_wdata = 0;
    #12;
    chk("rst_flush", flush, 0);
    chk("rst_busy", busy, 0);
    chk("rst_redirect", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_mie", mstatus_mie, 0);
    csr_read("rst_mstatus", CSR_MSTATUS, 32'h1800);
    csr_read("rst_mepc", CSR_MEPC, 0);
    @(negedge clk);
    rst_n = 1;

    foreach (vt[i]) begin
      case (vt[i].op)
        0: mtvec = vt[i].a;
        1: run_req(0, vt[i].irq, vt[i].code, vt[i].a, vt[i].d, vt[i].exp);
        2: run_req(1, 0, 0, 0, 0, vt[i].exp);
        3: csr_write(vt[i].a[11:0], vt[i].d);
        default: csr_read(vt[i].nm, vt[i].a[11:0], vt[i].exp);
      endcase
    end

    // Simultaneous trap, mret and CSR write: only the trap takes effect;
    // then requests while busy are dropped.
    mtvec = 32'h0000_0004;
    @(negedge clk);
    trap_req = 1; trap_is_irq = 0; trap_code = CAUSE_ECALL_M; trap_pc = 32'h300; trap_val = 32'h77;
    mret_req = 1; csr_we = 1; csr_addr = CSR_MTVAL; csr_wdata = 32'h99;
    sbq.push_back(32'h4);
    @(negedge clk);
    trap_req = 0; mret_req = 0; csr_we = 0;
    chk("prio_redirect", redirect_valid, 1);
    @(negedge clk);
    chk("prio_in_flush", flush, 1);
    trap_req = 1; trap_code = CAUSE_ILLEGAL_INSTR; trap_pc = 32'h400;
    csr_we = 1; csr_addr = CSR_MCAUSE; csr_wdata = 32'hAA;
    @(negedge clk);
    trap_req = 0; csr_we = 0;
    chk("busy_drop_idle", busy, 0);
    csr_read("prio_mcause", CSR_MCAUSE, 32'hB);
    csr_read("prio_mtval", CSR_MTVAL, 32'h77);
    csr_read("prio_mepc", CSR_MEPC, 32'h300);

    // Target is latched at the request edge; a later mtvec change has no effect.
    mtvec = 32'h0000_2000;
    @(negedge clk);
    trap_req = 1; trap_is_irq = 0; trap_code = 5'd1; trap_pc = 32'h500;
    sbq.push_back(32'h2000);
    @(posedge clk);
    #1;
    mtvec = 32'h0000_3000;
    trap_req = 0;
    @(negedge clk);
    chk("latch_redirect", redirect_valid, 1);
    wait_idle("latch_flush_len");

    // Reset asserted during FLUSH drops everything immediately.
    csr_write(CSR_MSTATUS, 32'h8);
    @(negedge clk);
    trap_req = 1; trap_is_irq = 1; trap_code = 5'd3; trap_pc = 32'h600;
    sbq.push_back(32'h3000);
    @(negedge clk);
    trap_req = 0;
    @(negedge clk);
    chk("pre_rst_flush", flush, 1);
    #2;
    rst_n = 0;
    #1;
    chk("midrst_flush", flush, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_redirect", redirect_valid, 0);
    chk("midrst_mie", mstatus_mie, 0);
    csr_read("midrst_mstatus", CSR_MSTATUS, 32'h1800);
    csr_read("midrst_mepc", CSR_MEPC, 0);
    csr_read("midrst_mcause", CSR_MCAUSE, 0);
    csr_read("midrst_mtval", CSR_MTVAL, 0);
    csr_read("midrst_mscratch", CSR_MSCRATCH, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("sb_drain", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/m_trap_handler.md
Name: m_trap_handler

Overview:
Machine-mode trap entry/return unit, directly downstream of the trap-setup register block. It consumes `mtvec` and takes trap/mret requests from the execute stage. It commits `mepc`, `mcause`, `mtval` and `mstatus`, then drives a one-shot PC redirect followed by a counted pipeline flush. It owns the trap-handling CSRs and serves their reads and writes.

Parameters:
- FLUSH_CYCLES, 2, cycles `flush` stays high after a redirect (min 1).
- RESET_MIE, 0, reset value of `mstatus.MIE`.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mtvec  in  32  `{BASE[31:2], MODE[1:0]}` from the trap-setup block
- trap_req  in  1  trap request, single-cycle qualifier
- trap_is_irq  in  1  1 = interrupt, 0 = exception
- trap_code  in  5  exception/interrupt code
- trap_pc  in  32  PC of the faulting or interrupted instruction
- trap_val  in  32  value to record in `mtval`
- mret_req  in  1  MRET retiring
- csr_we  in  1  CSR write strobe
- csr_addr  in  12  CSR address
- csr_wdata  in  32  CSR write data
- csr_rdata  out  32  combinational read of `csr_addr` (0 if unmapped)
- redirect_valid  out  1  one-cycle PC redirect pulse
- redirect_pc  out  32  target PC; valid only with `redirect_valid`
- flush  out  1  pipeline flush
- busy  out  1  high outside IDLE
- mstatus_mie  out  1  global interrupt enable

Behaviour:
- Reset (async, `rst_n`=0):
  - state=IDLE; `mepc`=0, `mcause`=0, `mtval`=0; MIE=RESET_MIE, MPIE=0; flush counter=0.
  - All outputs are 0, except `mstatus_mie`=RESET_MIE and `csr_rdata`, which is combinational.
- FSM states: IDLE, REDIRECT, FLUSH.
- IDLE, one request sampled per rising edge. Priority: `trap_req` > `mret_req` > `csr_we`. Lower-priority inputs in the same cycle are dropped.
  - trap_req:
    - `mepc`←{trap_pc[31:2],2'b00}
    - `mcause`←{trap_is_irq, 26'b0, trap_code}
    - `mtval`←trap_val
    - MPIE←MIE, MIE←0
    - latch target; → REDIRECT
  - mret_req:
    - MIE←MPIE, MPIE←1
    - latch target=`mepc`; → REDIRECT
  - csr_we: write the addressed CSR; stay in IDLE.
- Trap target:
  - base={mtvec[31:2],2'b00}.
  - MODE=1 and interrupt: base + (trap_code<<2), 32-bit wrap-around.
  - Otherwise (MODE 0, 2 or 3, or any exception): base.
- REDIRECT (1 cycle):
  - `redirect_valid`=1, `redirect_pc`=latched target, `flush`=1.
  - → FLUSH with counter=FLUSH_CYCLES-1; if that is 0, → IDLE.
- FLUSH:
  - `flush`=1; counter decrements each cycle; → IDLE when counter reaches 0.
  - Total flush length is FLUSH_CYCLES cycles including REDIRECT.
- Latency: request at edge N → `redirect_valid` high during cycle N+1. The target is latched, so `mtvec` changes after edge N do not affect it.
- `busy`=1 in REDIRECT and FLUSH. `trap_req`, `mret_req` and `csr_we` are ignored while busy; upstream is flushed anyway.
- CSR map:
  - `mstatus` 0x300: bit3 MIE, bit7 MPIE, bits[12:11] MPP read 2'b11; all other bits read 0 and ignore writes.
  - `mepc` 0x341: write forces bits[1:0]=0.
  - `mcause` 0x342: full read/write.
  - `mtval` 0x343: full read/write.
  - Unmapped writes are ignored.
- Reset mid-FLUSH: immediate return to IDLE; `flush` and `redirect_valid` drop asynchronously.

Optional Feature:
- M_TRAP_MSCRATCH_EN defined: adds 32-bit read/write `mscratch` at 0x340, reset 0, written only in IDLE.
- Undefined: 0x340 reads 0 and writes are ignored.

Decomposition:
- Shared package `csr_pkg`:
  - CSR address constants (0x300, 0x340–0x343).
  - mtvec MODE encodings (DIRECT=0, VECTORED=1).
  - Standard cause codes: illegal instr=2, ecall-M=11, M-timer irq=7.
  - FSM state enum.
- Sub-module `m_trap_vector_calc`: combinational target computation from `mtvec`, `trap_is_irq` and `trap_code`.

Test Plan:
1. Direct mode, exception.
   - Stimulus: mtvec=0x0000_0004, MIE=1; trap_req with irq=0, code=2, trap_pc=0x100, trap_val=0xDEAD_BEEF.
   - Response, next cycle: redirect_pc=0x4; mepc=0x100, mcause=0x2, mtval=0xDEAD_BEEF; MIE=0, MPIE=1.
   - `flush` high for exactly 2 cycles.
2. Vectored interrupt.
   - Stimulus: mtvec=0x0000_1001; irq=1, code=7.
   - Response: redirect_pc=0x101C; mcause=0x8000_0007.
   - Stimulus (exception with same mtvec): code=11.
   - Response: redirect_pc=0x1000.
3. MRET after scenario 1.
   - Stimulus: mret_req.
   - Response: redirect_pc=0x100; MIE=1, MPIE=1.
4. Simultaneous trap_req and mret_req, then a request while busy.
   - Response: only the trap is taken.
   - Stimulus: second trap_req during FLUSH.
   - Response: ignored; mcause unchanged.
5. CSR access.
   - Write 0x341 with 0x0000_0203 → reads 0x0000_0200.
   - Write 0x300 with 0xFFFF_FFFF → reads 0x0000_1888.
   - 0x340 behaviour checked with M_TRAP_MSCRATCH_EN defined and undefined.
6. Reset mid-operation.
   - Stimulus: assert `rst_n` low during FLUSH.
   - Response: flush=0 and busy=0 immediately; all CSRs at reset values.
